// File: rtl/mipi_csi2_pkt_dec.sv
// mipi_csi2_pkt_dec
// CSI-2 packet layer: turns the PHY byte stream into a pixel stream with
// frame/line valids. Decodes FS/FE short packets and RAW8/RAW10/RAW12 long
// packets on one selected virtual channel. It checks the payload CRC-16 and
// flags word-count and truncation errors.
//
// Ports
//   clk        PHY byte clock
//   reset      synchronous, active-high
//   enable     new packets accepted only while high (sampled in IDLE)
//   byte_we    byte valid, high for the whole packet
//   byte_data  packet byte
//   vc_sel     virtual channel to accept
//   dato       pixel, LSB-justified, upper bits zero
//   dvo        pixel valid
//   lvo        line valid
//   fvo        frame valid
//   frame_cnt  accepted Frame Starts (wraps)
//   line_cnt   completed image lines in current frame
//   crc_err    one-cycle pulse on payload CRC mismatch
//   wc_err     one-cycle pulse on bad word count or truncated packet
module mipi_csi2_pkt_dec #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  byte_we,
  input  logic [7:0]            byte_data,
  input  logic [1:0]            vc_sel,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  dvo,
  output logic                  lvo,
  output logic                  fvo,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  line_cnt,
  output logic                  crc_err,
  output logic                  wc_err
);

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_CRC, S_DRAIN, S_SKIP
  } state_t;

  typedef enum logic [1:0] {M_RAW8, M_RAW10, M_RAW12} mode_t;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  state_t      state, state_n;
  mode_t       mode, img_mode;
  logic [1:0]  hdr_idx;
  logic [7:0]  di;
  logic [15:0] wc;
  logic [15:0] byte_cnt;
  logic [2:0]  grp_idx;
  logic [7:0]  grp [4];
  pix_t        shadow [3];
  logic [1:0]  sh_cnt;
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  logic        crc_idx;

  logic start_img, is_fs, is_fe, pay_last, abort, drain_done;
  pix_t p10 [4];
  pix_t p12 [2];

  function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                             input logic [7:0]  d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Pixels of a group, valid on the cycle its last byte is on byte_data.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++)
      p10[k] = pix_t'({grp[k], byte_data[2*k +: 2]});
    p12[0] = pix_t'({grp[0], byte_data[3:0]});
    p12[1] = pix_t'({grp[1], byte_data[7:4]});
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_img  = 1'b0;
    img_mode   = M_RAW8;
    is_fs      = 1'b0;
    is_fe      = 1'b0;
    pay_last   = 1'b0;
    abort      = 1'b0;
    drain_done = 1'b0;
    case (state)
      S_IDLE:
        if (byte_we && enable) state_n = S_HEADER;
      S_HEADER:
        if (!byte_we) state_n = S_IDLE;
        else if (hdr_idx == 2'd3) begin
          state_n = S_SKIP;
          if (di[7:6] == vc_sel) begin
            case (di[5:0])
              DT_FS:    is_fs = 1'b1;
              DT_FE:    is_fe = 1'b1;
              DT_RAW8:  begin start_img = 1'b1; img_mode = M_RAW8;  end
              DT_RAW10: begin start_img = 1'b1; img_mode = M_RAW10; end
              DT_RAW12: begin start_img = 1'b1; img_mode = M_RAW12; end
              default: ;
            endcase
          end
          if (start_img) state_n = (wc == 16'd0) ? S_CRC : S_PAYLOAD;
        end
      S_PAYLOAD:
        if (!byte_we) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end else if (byte_cnt == wc - 16'd1) begin
          pay_last = 1'b1;
          state_n  = S_CRC;
        end
      S_CRC:
        if (!byte_we) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end else if (crc_idx) begin
          state_n = S_DRAIN;
        end
      S_DRAIN:
        // The pixel loaded last edge is on dato now; lvo drops after it.
        if (sh_cnt == 2'd0) begin
          drain_done = 1'b1;
          state_n    = byte_we ? S_SKIP : S_IDLE;
        end
      S_SKIP:
        if (!byte_we) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dato      <= '0;
      dvo       <= 1'b0;
      lvo       <= 1'b0;
      fvo       <= 1'b0;
      frame_cnt <= '0;
      line_cnt  <= '0;
      crc_err   <= 1'b0;
      wc_err    <= 1'b0;
      mode      <= M_RAW8;
      hdr_idx   <= '0;
      di        <= '0;
      wc        <= '0;
      byte_cnt  <= '0;
      grp_idx   <= '0;
      sh_cnt    <= '0;
      crc       <= '1;
      crc_lo    <= '0;
      crc_idx   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) grp[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) shadow[i] <= '0;
    end else begin
      crc_err <= 1'b0;
      wc_err  <= 1'b0;

      if (sh_cnt != 2'd0) begin
        dato      <= shadow[0];
        shadow[0] <= shadow[1];
        shadow[1] <= shadow[2];
        sh_cnt    <= sh_cnt - 2'd1;
        dvo       <= 1'b1;
      end else begin
        dvo <= 1'b0;
      end

      if (state == S_IDLE && byte_we && enable) begin
        di      <= byte_data;
        hdr_idx <= 2'd1;
      end

      if (state == S_HEADER && byte_we) begin
        hdr_idx <= hdr_idx + 2'd1;
        if (hdr_idx == 2'd1) wc[7:0]  <= byte_data;
        if (hdr_idx == 2'd2) wc[15:8] <= byte_data;
      end

      if (is_fs) begin
        fvo       <= 1'b1;
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        line_cnt  <= '0;
      end
      if (is_fe) fvo <= 1'b0;

      if (start_img) begin
        mode     <= img_mode;
        byte_cnt <= '0;
        grp_idx  <= '0;
        crc      <= 16'hFFFF;
        crc_idx  <= 1'b0;
      end

      if (state == S_PAYLOAD && byte_we) begin
        crc      <= crc16_byte(crc, byte_data);
        byte_cnt <= byte_cnt + 16'd1;
        case (mode)
          M_RAW8: begin
            dato <= pix_t'(byte_data);
            dvo  <= 1'b1;
            lvo  <= 1'b1;
          end
          M_RAW10:
            // Shadow is always empty here: a 5-byte group outlasts a 4-pixel drain.
            if (grp_idx == 3'd4) begin
              dato      <= p10[0];
              shadow[0] <= p10[1];
              shadow[1] <= p10[2];
              shadow[2] <= p10[3];
              sh_cnt    <= 2'd3;
              dvo       <= 1'b1;
              lvo       <= 1'b1;
              grp_idx   <= '0;
            end else begin
              grp[grp_idx[1:0]] <= byte_data;
              grp_idx           <= grp_idx + 3'd1;
            end
          M_RAW12:
            if (grp_idx == 3'd2) begin
              dato      <= p12[0];
              shadow[0] <= p12[1];
              sh_cnt    <= 2'd1;
              dvo       <= 1'b1;
              lvo       <= 1'b1;
              grp_idx   <= '0;
            end else begin
              grp[grp_idx[1:0]] <= byte_data;
              grp_idx           <= grp_idx + 3'd1;
            end
          default: ;
        endcase
        // The last byte must close a group, otherwise WC was not a multiple.
        if (pay_last)
          wc_err <= (mode == M_RAW10 && grp_idx != 3'd4) ||
                    (mode == M_RAW12 && grp_idx != 3'd2);
      end

      if (state == S_CRC && byte_we) begin
        if (!crc_idx) begin
          crc_lo  <= byte_data;
          crc_idx <= 1'b1;
        end else begin
          crc_err <= (crc != {byte_data, crc_lo});
        end
      end

      if (drain_done) begin
        lvo <= 1'b0;
        if (lvo) line_cnt <= line_cnt + CNT_WIDTH'(1);
      end

      if (abort) begin
        wc_err  <= 1'b1;
        dvo     <= 1'b0;
        lvo     <= 1'b0;
        sh_cnt  <= '0;
        grp_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi2_pkt_dec.sv
module tb_mipi_csi2_pkt_dec;

  logic        clk = 1'b0;
  logic        reset, enable, byte_we;
  logic [7:0]  byte_data;
  logic [1:0]  vc_sel;
  logic [11:0] dato;
  logic        dvo, lvo, fvo, crc_err, wc_err;
  logic [15:0] frame_cnt, line_cnt;

  logic [11:0] w_dato;
  logic        w_dvo, w_lvo, w_fvo, w_crc_err, w_wc_err;
  logic [3:0]  w_frame_cnt, w_line_cnt;

  always #5 clk = ~clk;

  mipi_csi2_pkt_dec #(.DATA_WIDTH(12), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .byte_we(byte_we),
    .byte_data(byte_data), .vc_sel(vc_sel), .dato(dato), .dvo(dvo),
    .lvo(lvo), .fvo(fvo), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
    .crc_err(crc_err), .wc_err(wc_err)
  );

  // Narrow-counter instance so counter wrap is reachable in a short run.
  mipi_csi2_pkt_dec #(.DATA_WIDTH(12), .CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .reset(reset), .enable(enable), .byte_we(byte_we),
    .byte_data(byte_data), .vc_sel(vc_sel), .dato(w_dato), .dvo(w_dvo),
    .lvo(w_lvo), .fvo(w_fvo), .frame_cnt(w_frame_cnt), .line_cnt(w_line_cnt),
    .crc_err(w_crc_err), .wc_err(w_wc_err)
  );

  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int cnt_crc = 0, cnt_wc = 0, lvo_len = 0, last_lvo_len = 0;
  logic prev_lvo = 1'b0;
  int m_frame = 0, m_line = 0, m_fvo = 0, m_crc = 0, m_wc = 0;
  logic [7:0] pkt[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: scoreboard pops and pulse bookkeeping.
  always @(negedge clk) begin
    if (reset) begin
      lvo_len  = 0;
      prev_lvo = 1'b0;
    end else begin
      if (dvo) begin
        chk("dvo_within_lvo", lvo, 1);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pixel: got dato 0x%0h, expected no pixel", dato);
        end else begin
          chk("pixel", dato, exp_q.pop_front());
        end
      end
      if (lvo && !prev_lvo) chk("lvo_rise_with_dvo", dvo, 1);
      if (lvo) lvo_len++;
      else if (prev_lvo) begin
        last_lvo_len = lvo_len;
        lvo_len = 0;
      end
      prev_lvo = lvo;
      if (crc_err) cnt_crc++;
      if (wc_err)  cnt_wc++;
    end
  end

  function automatic int crc16(input logic [7:0] d[$]);
    int c = 'hFFFF;
    foreach (d[i])
      for (int b = 0; b < 8; b++)
        if (((c ^ (int'(d[i]) >> b)) & 1) != 0) c = (c >> 1) ^ 'h8408;
        else c = c >> 1;
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int nbytes, input int gap);
    int n = (nbytes < 0) ? pkt.size() : nbytes;
    for (int i = 0; i < n; i++) begin
      byte_we = 1'b1; byte_data = pkt[i]; tick(1);
    end
    byte_we = 1'b0; byte_data = 8'h00;
    tick(gap);
  endtask

  task automatic post_check(input string tag);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
    chk({tag, "_crc_err_cnt"}, cnt_crc, m_crc);
    chk({tag, "_wc_err_cnt"}, cnt_wc, m_wc);
    chk({tag, "_frame_cnt"}, frame_cnt, m_frame & 'hFFFF);
    chk({tag, "_line_cnt"}, line_cnt, m_line & 'hFFFF);
    chk({tag, "_fvo"}, fvo, m_fvo);
    chk({tag, "_lvo_idle"}, lvo, 0);
    chk({tag, "_w4_frame_cnt"}, w_frame_cnt, m_frame % 16);
    chk({tag, "_w4_line_cnt"}, w_line_cnt, m_line % 16);
  endtask

  task automatic do_short(input int vc, input int dt, input string tag);
    pkt.delete();
    pkt.push_back(8'((vc << 6) | dt));
    pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h00);
    if (enable && vc == int'(vc_sel)) begin
      if (dt == 0) begin m_frame++; m_line = 0; m_fvo = 1; end
      else if (dt == 1) m_fvo = 0;
    end
    send(-1, 6);
    post_check(tag);
  endtask

  // cut >= 0: byte_we drops after that many payload bytes.
  // xp non-empty: directed expected pixels instead of the model's.
  task automatic do_line(input int vc, input int dt, input logic [7:0] pl[$],
                         input int crc_val, input int cut, input int xp[$],
                         input string tag);
    int wc = pl.size();
    int np = 0;
    pkt.delete();
    pkt.push_back(8'((vc << 6) | dt));
    pkt.push_back(8'(wc)); pkt.push_back(8'(wc >> 8)); pkt.push_back(8'h5A);
    foreach (pl[i]) pkt.push_back(pl[i]);
    pkt.push_back(8'(crc_val)); pkt.push_back(8'(crc_val >> 8));
    if (enable && vc == int'(vc_sel) && dt >= 'h2A && dt <= 'h2C) begin
      if (xp.size() > 0) begin
        foreach (xp[i]) exp_q.push_back(xp[i]);
        np = xp.size();
      end else if (dt == 'h2A) begin
        np = (cut < 0) ? wc : cut;
        for (int i = 0; i < np; i++) exp_q.push_back(int'(pl[i]));
      end else if (dt == 'h2B) begin
        for (int g = 0; g + 5 <= wc; g += 5)
          for (int k = 0; k < 4; k++) begin
            exp_q.push_back((int'(pl[g+k]) << 2) | ((int'(pl[g+4]) >> (2*k)) & 3));
            np++;
          end
      end else begin
        for (int g = 0; g + 3 <= wc; g += 3) begin
          exp_q.push_back((int'(pl[g]) << 4) | (int'(pl[g+2]) & 15));
          exp_q.push_back((int'(pl[g+1]) << 4) | (int'(pl[g+2]) >> 4));
          np += 2;
        end
      end
      if (cut >= 0) m_wc++;
      else begin
        if (np > 0) m_line++;
        if ((dt == 'h2B && wc % 5 != 0) || (dt == 'h2C && wc % 3 != 0)) m_wc++;
        if (crc16(pl) != crc_val) m_crc++;
      end
    end
    send((cut < 0) ? -1 : 4 + cut, 8);
    post_check(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[$];
    int none[$];
    int xp[$];

    reset = 1'b1; enable = 1'b1; byte_we = 1'b0; byte_data = 8'h00; vc_sel = 2'd0;
    tick(3);
    chk("rst_dato", dato, 0); chk("rst_dvo", dvo, 0); chk("rst_lvo", lvo, 0);
    chk("rst_fvo", fvo, 0); chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_cnt", line_cnt, 0); chk("rst_crc_err", crc_err, 0);
    chk("rst_wc_err", wc_err, 0);
    reset = 1'b0;
    tick(2);

    // FS, RAW8 line with known-good CRC, FE; then bad CRC.
    do_short(0, 0, "fs1");
    pl = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4,
           8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF,
           8'hFF, 8'h00, 8'h00, 8'h01};
    do_line(0, 'h2A, pl, 'h00F0, -1, none, "raw8_good_crc");
    chk("raw8_lvo_len_ge_24", (last_lvo_len >= 24) ? 1 : 0, 1);
    do_short(0, 1, "fe1");
    do_line(0, 'h2A, pl, 'h00F1, -1, none, "raw8_bad_crc");

    // RAW10 single group: four pixels, lvo exactly four cycles.
    do_short(0, 0, "fs2");
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
    xp = '{'h048, 'h0D1, 'h15A, 'h1E3};
    do_line(0, 'h2B, pl, crc16(pl), -1, xp, "raw10_wc5");
    chk("raw10_lvo_len", last_lvo_len, 4);

    // RAW12 two groups.
    pl = '{8'hAB, 8'hCD, 8'h21, 8'hAB, 8'hCD, 8'h21};
    xp = '{'hAB1, 'hCD2, 'hAB1, 'hCD2};
    do_line(0, 'h2C, pl, crc16(pl), -1, xp, "raw12_wc6");

    // Virtual-channel filtering.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_short(1, 0, "vc1_fs_rejected");
    do_line(1, 'h2A, pl, crc16(pl), -1, none, "vc1_line_rejected");
    vc_sel = 2'd1;
    do_short(1, 0, "vc1_fs_accepted");
    do_line(1, 'h2A, pl, crc16(pl), -1, none, "vc1_line_accepted");
    vc_sel = 2'd0;

    // RAW10 WC=7: one group plus a partial group.
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4, 8'hAA, 8'hBB};
    do_line(0, 'h2B, pl, crc16(pl), -1, none, "raw10_wc7");

    // RAW8 WC=10 truncated after six payload bytes, then a normal FS.
    pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0};
    do_line(0, 'h2A, pl, crc16(pl), 6, none, "raw8_trunc");
    do_short(0, 0, "fs_after_trunc");

    // Randomized traffic on vc_sel=0.
    for (int it = 0; it < 40; it++) begin
      int r, vc, dt, wc, crcv, cut;
      enable = ($urandom_range(0, 5) != 0);
      vc = ($urandom_range(0, 4) == 0) ? 2 : 0;
      r = $urandom_range(0, 9);
      pl.delete();
      if (r == 0) do_short(vc, 0, "rnd_fs");
      else if (r == 1) do_short(vc, 1, "rnd_fe");
      else begin
        dt = (r <= 7) ? ('h2A + $urandom_range(0, 2)) : 'h12;
        wc = $urandom_range(0, (dt == 'h2A) ? 20 : (dt == 'h2B) ? 17 : 13);
        repeat (wc) pl.push_back(8'($urandom));
        crcv = crc16(pl) ^ (($urandom_range(0, 4) == 0) ? 'h0100 : 0);
        cut = -1;
        if (dt == 'h2A && wc > 0 && $urandom_range(0, 5) == 0) cut = $urandom_range(1, wc);
        do_line(vc, dt, pl, crcv, cut, none, "rnd_line");
      end
    end
    enable = 1'b1;

    // Reset in the middle of a RAW10 payload.
    do_short(0, 0, "fs_pre_reset");
    pkt.delete();
    pkt = '{8'h2B, 8'h0A, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 7; i++) begin
      byte_we = 1'b1; byte_data = pkt[i]; tick(1);
    end
    reset = 1'b1;
    tick(1);
    chk("midrst_dato", dato, 0); chk("midrst_dvo", dvo, 0); chk("midrst_lvo", lvo, 0);
    chk("midrst_fvo", fvo, 0); chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_line_cnt", line_cnt, 0); chk("midrst_crc_err", crc_err, 0);
    chk("midrst_wc_err", wc_err, 0);
    reset = 1'b0; byte_we = 1'b0; byte_data = 8'h00;
    m_frame = 0; m_line = 0; m_fvo = 0;
    exp_q.delete();
    tick(4);
    do_short(0, 0, "fs_post_reset");
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
    do_line(0, 'h2B, pl, crc16(pl), -1, none, "raw10_post_reset");

    // Frame counter wrap on the narrow instance (15 -> 0 at the 16th FS).
    for (int i = 0; i < 17; i++) do_short(0, 0, "fs_wrap");

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
